rgmii_tx_ddr_framer: RTL and testbench

//  Transmit-side companion of the RGMII source-synchronous DDR input path.

---
 rtl/rgmii_tx_ddr_framer_pkg.sv | 20 ++
 rtl/rgmii_tx_nibble_ser.sv | 77 +++++++
 rtl/rgmii_tx_ddr_framer.sv | 155 +++++++++++++++
 tb/tb_rgmii_tx_ddr_framer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_tx_ddr_framer_pkg.sv
// rtl/rgmii_tx_ddr_framer_pkg.sv - shared types and constants for the RGMII TX framer
package rgmii_tx_ddr_framer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        IFG
    } state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    function automatic int cnt_width(input int pre_bytes, input int ifg_bytes);
        int span;
        span = (pre_bytes + 1 > ifg_bytes) ? pre_bytes + 1 : ifg_bytes;
        return (span < 2) ? 1 : $clog2(span);
    endfunction

endpackage

// File: rtl/rgmii_tx_nibble_ser.sv
// rtl/rgmii_tx_nibble_ser.sv - byte-to-DDR nibble mapping with registered pin outputs
module rgmii_tx_nibble_ser (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       mii_i,
    input  logic       run_i,
    input  logic [7:0] byte_i,
    input  logic       en_i,
    input  logic       er_i,
    output logic       phase_o,
    output logic [3:0] txd_q1_o,
    output logic [3:0] txd_q2_o,
    output logic       txctl_q1_o,
    output logic       txctl_q2_o
);

    logic       phase_q, phase_d;
    logic [3:0] hi_q, hi_d;
    logic       en_q, en_d;
    logic       er_q, er_d;
    logic [3:0] txd1_q, txd1_d;
    logic [3:0] txd2_q, txd2_d;
    logic       ctl1_q, ctl1_d;
    logic       ctl2_q, ctl2_d;
    logic       load;

    // A new byte is taken every clk in gigabit; in mii only on phase 0, phase 1 replays the held high nibble.
    always_comb begin
        phase_d = mii_i & run_i & ~phase_q;
        load    = ~mii_i | ~phase_q;
        hi_d    = hi_q;
        en_d    = en_q;
        er_d    = er_q;
        txd1_d  = hi_q;
        txd2_d  = hi_q;
        ctl1_d  = en_q;
        ctl2_d  = en_q ^ er_q;
        if (load) begin
            hi_d   = byte_i[7:4];
            en_d   = en_i;
            er_d   = er_i;
            txd1_d = byte_i[3:0];
            txd2_d = mii_i ? byte_i[3:0] : byte_i[7:4];
            ctl1_d = en_i;
            ctl2_d = en_i ^ er_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            txd1_q  <= '0;
            txd2_q  <= '0;
            ctl1_q  <= 1'b0;
            ctl2_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            en_q    <= en_d;
            er_q    <= er_d;
            txd1_q  <= txd1_d;
            txd2_q  <= txd2_d;
            ctl1_q  <= ctl1_d;
            ctl2_q  <= ctl2_d;
        end
    end

    assign phase_o    = phase_q;
    assign txd_q1_o   = txd1_q;
    assign txd_q2_o   = txd2_q;
    assign txctl_q1_o = ctl1_q;
    assign txctl_q2_o = ctl2_q;

endmodule

// File: rtl/rgmii_tx_ddr_framer.sv
// rtl/rgmii_tx_ddr_framer.sv - RGMII transmit framer: preamble/SFD insertion, IFG, DDR nibble pairs
module rgmii_tx_ddr_framer
    import rgmii_tx_ddr_framer_pkg::*;
#(
    parameter int preamble_bytes_p = 7,
    parameter int ifg_bytes_p      = 12
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       mii_mode_i,
    input  logic [7:0] data_i,
    input  logic       v_i,
    input  logic       last_i,
    output logic       ready_o,
    output logic [3:0] txd_q1_o,
    output logic [3:0] txd_q2_o,
    output logic       txctl_q1_o,
    output logic       txctl_q2_o,
    output logic       busy_o,
    output logic       underflow_o
);

    localparam int                CNT_W    = cnt_width(preamble_bytes_p, ifg_bytes_p);
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(preamble_bytes_p);
    localparam logic [CNT_W-1:0]  IFG_LAST = CNT_W'(ifg_bytes_p - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             fin_q, fin_d;
    logic             drop_q, drop_d;
    logic             uf_q, uf_d;
    logic [7:0]       byte_s;
    logic             en_s, er_s, ready_s;
    logic             phase, slot, bt_end;
    logic [CNT_W-1:0] cnt_inc;

    // slot: cycle that starts a byte-time; bt_end: cycle that closes one.
    assign slot    = ~mode_q | ~phase;
    assign bt_end  = ~mode_q | phase;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fin_d   = fin_q;
        drop_d  = drop_q;
        uf_d    = 1'b0;
        byte_s  = 8'h00;
        en_s    = 1'b0;
        er_s    = 1'b0;
        ready_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (v_i) begin
                    mode_d  = mii_mode_i;
                    cnt_d   = '0;
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                en_s   = 1'b1;
                byte_s = (cnt_q < PRE_LAST) ? PREAMBLE_BYTE : SFD_BYTE;
                if (bt_end) begin
                    if (cnt_q >= PRE_LAST) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            DATA: begin
                en_s    = 1'b1;
                ready_s = slot;
                if (slot) begin
                    fin_d = ~v_i | last_i;
                    if (v_i) begin
                        byte_s = data_i;
                    end else begin
                        er_s   = 1'b1;
                        uf_d   = 1'b1;
                        drop_d = 1'b1;
                    end
                end
                // In mii the end decision is remembered from phase 0 and acted on at phase 1.
                if (bt_end && fin_d) begin
                    state_d = IFG;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                end
            end
            IFG: begin
                ready_s = drop_q & slot;
                if (ready_s && v_i && last_i) begin
                    drop_d = 1'b0;
                end
                if (bt_end) begin
                    if (cnt_q >= IFG_LAST) begin
                        cnt_d  = '0;
                        drop_d = 1'b0;
                        if (v_i && !drop_q) begin
                            mode_d  = mii_mode_i;
                            state_d = PREAMBLE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            fin_q   <= 1'b0;
            drop_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fin_q   <= fin_d;
            drop_q  <= drop_d;
            uf_q    <= uf_d;
        end
    end

    rgmii_tx_nibble_ser u_ser (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .mii_i      (mode_q),
        .run_i      (state_q != IDLE),
        .byte_i     (byte_s),
        .en_i       (en_s),
        .er_i       (er_s),
        .phase_o    (phase),
        .txd_q1_o   (txd_q1_o),
        .txd_q2_o   (txd_q2_o),
        .txctl_q1_o (txctl_q1_o),
        .txctl_q2_o (txctl_q2_o)
    );

    assign ready_o     = ready_s;
    assign busy_o      = (state_q != IDLE);
    assign underflow_o = uf_q;

endmodule

// File: tb/tb_rgmii_tx_ddr_framer.sv
// tb/tb_rgmii_tx_ddr_framer.sv - scoreboard bench for the RGMII TX framer
module tb_rgmii_tx_ddr_framer;

    localparam int PRE = 7;
    localparam int IFG = 12;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b1;
    logic       mii_mode_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       v_i = 1'b0;
    logic       last_i = 1'b0;
    logic       ready_o;
    logic [3:0] txd_q1_o, txd_q2_o;
    logic       txctl_q1_o, txctl_q2_o, busy_o, underflow_o;

    rgmii_tx_ddr_framer dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .mii_mode_i  (mii_mode_i),
        .data_i      (data_i),
        .v_i         (v_i),
        .last_i      (last_i),
        .ready_o     (ready_o),
        .txd_q1_o    (txd_q1_o),
        .txd_q2_o    (txd_q2_o),
        .txctl_q1_o  (txctl_q1_o),
        .txctl_q2_o  (txctl_q2_o),
        .busy_o      (busy_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    // stim entry {v, last, data}; sb entry {in_frame, q1, q2, ctl1, ctl2, underflow}
    logic [9:0]  stim[$];
    logic [11:0] sb[$];
    logic [7:0]  frm[$];
    logic [10:0] obs;
    logic [11:0] exp_e;
    logic        rdy_s, busy_s, hs_s, want_busy;
    int          checks = 0;
    int          errors = 0;

    function automatic void push_out(input logic [3:0] a, input logic [3:0] b, input logic c1,
                                     input logic c2, input logic uf, input logic f);
        sb.push_back({f, a, b, c1, c2, uf});
    endfunction

    function automatic void push_byte(input logic [7:0] b, input logic en, input logic er,
                                      input logic uf, input bit mii);
        if (mii) begin
            push_out(b[3:0], b[3:0], en, en ^ er, uf, 1'b1);
            push_out(b[7:4], b[7:4], en, en ^ er, 1'b0, 1'b1);
        end else begin
            push_out(b[3:0], b[7:4], en, en ^ er, uf, 1'b1);
        end
    endfunction

    function automatic void push_idle(input int n);
        repeat (n) push_out(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // uf_at = number of bytes sent before the source stalls (-1: no stall)
    function automatic void add_frame(input bit mii, input int uf_at);
        repeat (PRE) push_byte(8'h55, 1'b1, 1'b0, 1'b0, mii);
        push_byte(8'hD5, 1'b1, 1'b0, 1'b0, mii);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == uf_at) begin
                stim.push_back(10'h000);
                push_byte(8'h00, 1'b1, 1'b1, 1'b1, mii);
            end
            stim.push_back({1'b1, (i == frm.size() - 1), frm[i]});
            if (uf_at < 0 || i < uf_at) push_byte(frm[i], 1'b1, 1'b0, 1'b0, mii);
        end
        repeat (IFG) push_byte(8'h00, 1'b0, 1'b0, 1'b0, mii);
        frm.delete();
    endfunction

    task automatic tick();
        logic [9:0] e;
        e = (stim.size() != 0) ? stim[0] : 10'h000;
        @(posedge clk_i);
        #1;
        v_i    = e[9];
        last_i = e[8];
        data_i = e[7:0];
        @(negedge clk_i);
        obs    = {txd_q1_o, txd_q2_o, txctl_q1_o, txctl_q2_o, underflow_o};
        rdy_s  = ready_o;
        busy_s = busy_o;
        hs_s   = e[9] & ready_o;
        if (stim.size() != 0 && (!e[9] || ready_o)) e = stim.pop_front();
    endtask

    task automatic test_reset();
        #1 reset_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        obs = {txd_q1_o, txd_q2_o, txctl_q1_o, txctl_q2_o, underflow_o};
        checks++;
        if (obs !== 11'h000) begin errors++; $display("FAIL reset_out: got %h want 000", obs); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        reset_n_i = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (obs !== 11'h000 || busy_s !== 1'b0) begin
                errors++; $display("FAIL idle_after_reset: got %h/%b want 000/0", obs, busy_s);
            end
        end
    endtask

    task automatic test_gig_frame();
        mii_mode_i = 1'b0;
        frm = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_idle(2); add_frame(1'b0, -1); push_idle(3);
        while (sb.size() != 0) begin
            tick();
            exp_e = sb.pop_front();
            want_busy = (sb.size() != 0) ? sb[0][11] : 1'b0;
            checks++;
            if (obs !== exp_e[10:0]) begin errors++; $display("FAIL gig_out: got %h want %h", obs, exp_e[10:0]); end
            checks++;
            if (busy_s !== want_busy) begin errors++; $display("FAIL gig_busy: got %b want %b", busy_s, want_busy); end
        end
    endtask

    task automatic test_mii_frame();
        bit prev_hs = 1'b0;
        int hs_cnt = 0;
        mii_mode_i = 1'b1;
        frm = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_idle(2); add_frame(1'b1, -1); push_idle(3);
        while (sb.size() != 0) begin
            tick();
            exp_e = sb.pop_front();
            want_busy = (sb.size() != 0) ? sb[0][11] : 1'b0;
            checks++;
            if (obs !== exp_e[10:0]) begin errors++; $display("FAIL mii_out: got %h want %h", obs, exp_e[10:0]); end
            checks++;
            if (busy_s !== want_busy) begin errors++; $display("FAIL mii_busy: got %b want %b", busy_s, want_busy); end
            if (prev_hs) begin
                checks++;
                if (rdy_s !== 1'b0) begin errors++; $display("FAIL mii_ready_alt: got %b want 0", rdy_s); end
            end
            prev_hs = hs_s;
            if (hs_s) hs_cnt++;
        end
        checks++;
        if (hs_cnt != 4) begin errors++; $display("FAIL mii_handshakes: got %0d want 4", hs_cnt); end
        mii_mode_i = 1'b0;
    endtask

    task automatic test_underflow();
        mii_mode_i = 1'b0;
        frm = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_idle(2); add_frame(1'b0, 2); push_idle(3);
        while (sb.size() != 0) begin
            tick();
            exp_e = sb.pop_front();
            want_busy = (sb.size() != 0) ? sb[0][11] : 1'b0;
            checks++;
            if (obs !== exp_e[10:0]) begin errors++; $display("FAIL uf_out: got %h want %h", obs, exp_e[10:0]); end
            checks++;
            if (busy_s !== want_busy) begin errors++; $display("FAIL uf_busy: got %b want %b", busy_s, want_busy); end
        end
        checks++;
        if (stim.size() != 0) begin errors++; $display("FAIL uf_drain: got %0d left want 0", stim.size()); end
        stim.delete();
    endtask

    task automatic test_back_to_back();
        mii_mode_i = 1'b0;
        push_idle(2);
        frm = '{8'h11, 8'h22};
        add_frame(1'b0, -1);
        frm = '{8'h33, 8'h44, 8'h55};
        add_frame(1'b0, -1);
        push_idle(3);
        while (sb.size() != 0) begin
            tick();
            exp_e = sb.pop_front();
            want_busy = (sb.size() != 0) ? sb[0][11] : 1'b0;
            checks++;
            if (obs !== exp_e[10:0]) begin errors++; $display("FAIL b2b_out: got %h want %h", obs, exp_e[10:0]); end
            checks++;
            if (busy_s !== want_busy) begin errors++; $display("FAIL b2b_busy: got %b want %b", busy_s, want_busy); end
        end
    endtask

    task automatic test_reset_mid_frame();
        mii_mode_i = 1'b0;
        for (int i = 1; i <= 8; i++) stim.push_back({1'b1, (i == 8), 8'(i)});
        repeat (12) tick();
        checks++;
        if (txctl_q1_o !== 1'b1) begin errors++; $display("FAIL mid_active: got %b want 1", txctl_q1_o); end
        #2 reset_n_i = 1'b0;
        #1;
        obs = {txd_q1_o, txd_q2_o, txctl_q1_o, txctl_q2_o, underflow_o};
        checks++;
        if (obs !== 11'h000 || busy_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset_out: got %h/%b want 000/0", obs, busy_o);
        end
        stim.delete();
        v_i = 1'b0; last_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        frm = '{8'hA5, 8'h3C};
        push_idle(2); add_frame(1'b0, -1); push_idle(3);
        while (sb.size() != 0) begin
            tick();
            exp_e = sb.pop_front();
            checks++;
            if (obs !== exp_e[10:0]) begin errors++; $display("FAIL post_reset_out: got %h want %h", obs, exp_e[10:0]); end
        end
    endtask

    task automatic test_mode_change();
        int n = 0;
        mii_mode_i = 1'b0;
        frm = '{8'h5A, 8'hC3};
        push_idle(2); add_frame(1'b0, -1); push_idle(3);
        while (sb.size() != 0) begin
            tick();
            n++;
            if (n == 6) mii_mode_i = 1'b1;
            exp_e = sb.pop_front();
            checks++;
            if (obs !== exp_e[10:0]) begin errors++; $display("FAIL mode_old_out: got %h want %h", obs, exp_e[10:0]); end
        end
        n = 0;
        frm = '{8'h96, 8'h0F};
        push_idle(2); add_frame(1'b1, -1); push_idle(3);
        while (sb.size() != 0) begin
            tick();
            n++;
            if (n == 8) mii_mode_i = 1'b0;
            exp_e = sb.pop_front();
            checks++;
            if (obs !== exp_e[10:0]) begin errors++; $display("FAIL mode_new_out: got %h want %h", obs, exp_e[10:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_gig_frame();
        test_mii_frame();
        test_underflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_mode_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
